sbit_frame_transmitter: RTL and testbench

- Transmit-side counterpart of the VFAT S-bit receive/alignment path. Produces VFAT3-style S-bit frames for loopback, emulation and self-test of the trigger receivers.
- Each clock, forms 8 lanes of 8-bit serializer words (one 320 Mb/s lane per S-bit pair, 8 slots per 40 MHz bunch crossing) plus the start-of-frame (SOF) word, for downstream 8:1 OSERDES.
- Supports test-pattern generation, programmable bunch-crossing delay and programmable bit-slip so the receiver's alignment logic can be exercised.

---
 rtl/sbit_frame_transmitter.sv | 146 ++++++++++++++
 tb/tb_sbit_frame_transmitter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sbit_frame_transmitter.sv
// VFAT3-style S-bit frame transmitter: pattern mux, bunch-crossing delay line and
// per-lane bit-slip, producing 8-bit serializer words for 8:1 OSERDES lanes.
module sbit_frame_transmitter #(
    parameter int         MXLANES   = 8,
    parameter int         MXDELAY   = 8,
    parameter logic [6:0] PRBS_SEED = 7'h7F
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [MXLANES-1:0]   lane_mask,
    input  logic [2:0]           delay,
    input  logic [2:0]           bitslip,
    input  logic [MXLANES*8-1:0] sbits_in,
    output logic [MXLANES*8-1:0] tx_words,
    output logic [7:0]           sof_word,
    output logic [15:0]          frame_cnt
);

    localparam int FW = MXLANES * 8;

    typedef logic [FW-1:0] frame_t;

    logic [15:0]        r_frame_cnt;
    logic [6:0]         r_prbs;
    logic [6:0]         w_prbs_state;
    logic [7:0]         w_prbs_byte;
    logic [6:0]         w_prbs_next;
    frame_t             w_onehot;
    frame_t             w_pat;

    frame_t             r_pat_p0;
    logic               r_vld_p0;

    frame_t             r_dly_p1 [MXDELAY];
    logic [MXDELAY-1:0] r_vld_dly_p1;
    frame_t             w_tap;
    logic               w_tap_vld;

    frame_t             w_cur;
    frame_t             w_slip;
    logic [7:0]         w_sof_cur;
    logic [7:0]         w_sof_slip;
    frame_t             r_prev_p2;
    frame_t             r_tx_p2;
    logic [7:0]         r_sof_prev_p2;
    logic [7:0]         r_sof_p2;

    // Eight PRBS7 (x^7+x^6+1) steps; returns {next state, bits in generation order}.
    function automatic logic [14:0] prbs_step8(input logic [6:0] seed);
        logic [6:0] st;
        logic [7:0] bits;
        logic       nb;
        st   = seed;
        bits = '0;
        for (int i = 0; i < 8; i++) begin
            nb      = st[6] ^ st[5];
            bits[i] = nb;
            st      = {st[5:0], nb};
        end
        return {st, bits};
    endfunction

    // Slot t of the result is stream[8+t-k] of the stream {cur, prev}.
    function automatic logic [7:0] slip8(input logic [7:0] cur, input logic [7:0] prev,
                                         input logic [2:0] k);
        logic [15:0] s;
        s = {cur, prev} >> (5'd8 - {2'b00, k});
        return s[7:0];
    endfunction

    assign {w_prbs_state, w_prbs_byte} = prbs_step8(r_prbs);
    assign w_onehot = frame_t'(1) << r_frame_cnt[5:0];

    always_comb begin
        w_pat       = '0;
        w_prbs_next = r_prbs;
        if (enable) begin
            unique case (mode)
                2'd0: w_pat = sbits_in;
                2'd1: begin
                    w_pat       = {MXLANES{w_prbs_byte}};
                    w_prbs_next = w_prbs_state;
                end
                2'd2: w_pat = w_onehot;
                default: w_pat = {MXLANES{r_frame_cnt[7:0]}};
            endcase
        end
    end

    // Stage 2 boundary: tap select on the delay line
    assign w_tap     = r_dly_p1[delay];
    assign w_tap_vld = r_vld_dly_p1[delay];

    // Stage 3 boundary: masking happens before the previous-frame register sees the word
    always_comb begin
        w_cur  = '0;
        w_slip = '0;
        for (int l = 0; l < MXLANES; l++) begin
            w_cur[l*8 +: 8]  = lane_mask[l] ? 8'h00 : w_tap[l*8 +: 8];
            w_slip[l*8 +: 8] = slip8(w_cur[l*8 +: 8], r_prev_p2[l*8 +: 8], bitslip);
        end
    end

    assign w_sof_cur  = {7'd0, w_tap_vld};
    assign w_sof_slip = slip8(w_sof_cur, r_sof_prev_p2, bitslip);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_frame_cnt   <= '0;
            r_prbs        <= PRBS_SEED;
            r_pat_p0      <= '0;
            r_vld_p0      <= 1'b0;
            r_vld_dly_p1  <= '0;
            for (int i = 0; i < MXDELAY; i++) begin
                r_dly_p1[i] <= '0;
            end
            r_prev_p2     <= '0;
            r_tx_p2       <= '0;
            r_sof_prev_p2 <= '0;
            r_sof_p2      <= '0;
        end else begin
            if (enable) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            r_prbs        <= w_prbs_next;
            r_pat_p0      <= w_pat;
            r_vld_p0      <= enable;
            r_dly_p1[0]   <= r_pat_p0;
            for (int i = 1; i < MXDELAY; i++) begin
                r_dly_p1[i] <= r_dly_p1[i-1];
            end
            r_vld_dly_p1  <= {r_vld_dly_p1[MXDELAY-2:0], r_vld_p0};
            r_prev_p2     <= w_cur;
            r_tx_p2       <= w_slip;
            r_sof_prev_p2 <= w_sof_cur;
            r_sof_p2      <= w_sof_slip;
        end
    end

    assign tx_words  = r_tx_p2;
    assign sof_word  = r_sof_p2;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_sbit_frame_transmitter.sv
// Directed bench for sbit_frame_transmitter: steady-state vector table plus
// hand-written sequences for latency, slip, PRBS, walking-one, wrap and reset.
module tb_sbit_frame_transmitter;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [7:0]  lane_mask;
    logic [2:0]  delay;
    logic [2:0]  bitslip;
    logic [63:0] sbits_in;
    logic [63:0] tx_words;
    logic [7:0]  sof_word;
    logic [15:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sbit_frame_transmitter #(
        .MXLANES  (8),
        .MXDELAY  (8),
        .PRBS_SEED(7'h7F)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .lane_mask(lane_mask),
        .delay    (delay),
        .bitslip  (bitslip),
        .sbits_in (sbits_in),
        .tx_words (tx_words),
        .sof_word (sof_word),
        .frame_cnt(frame_cnt)
    );

    typedef struct {
        logic [7:0]  mask;
        logic [2:0]  dly;
        logic [2:0]  slip;
        logic [63:0] sbits;
        logic [63:0] exp_tx;
        logic [7:0]  exp_sof;
    } vec_t;

    vec_t vecs [8];

    // PRBS7 reference: b[n] = b[n-7] ^ b[n-6], first 7 entries are the seed history.
    logic prbs_hist [0:8*160+7];

    function automatic logic [7:0] prbs_byte(input int k);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = prbs_hist[7 + 8*k + i];
        return b;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] hist [0:39];
        logic [7:0]  outb [0:139];
        logic [63:0] exp;
        logic [63:0] one;
        logic [7:0]  b;
        logic [6:0]  seed;

        seed = 7'h7F;
        for (int j = 0; j < 7; j++) prbs_hist[j] = seed[6-j];
        for (int j = 7; j < 8*160+8; j++) prbs_hist[j] = prbs_hist[j-7] ^ prbs_hist[j-6];

        vecs[0] = '{8'h00, 3'd0, 3'd0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 8'h01};
        vecs[1] = '{8'h04, 3'd0, 3'd0, 64'h0123456789ABCDEF, 64'h012345678900CDEF, 8'h01};
        vecs[2] = '{8'h04, 3'd5, 3'd0, 64'h0123456789ABCDEF, 64'h012345678900CDEF, 8'h01};
        vecs[3] = '{8'h00, 3'd0, 3'd1, 64'h0123456789ABCDEF, 64'h02468ACE13579BDF, 8'h02};
        vecs[4] = '{8'h00, 3'd2, 3'd4, 64'h0123456789ABCDEF, 64'h1032547698BADCFE, 8'h10};
        vecs[5] = '{8'hF0, 3'd7, 3'd0, 64'hFFFF0000AAAA5555, 64'h00000000AAAA5555, 8'h01};
        vecs[6] = '{8'hFF, 3'd3, 3'd7, 64'hFFFF0000AAAA5555, 64'h0000000000000000, 8'h80};
        vecs[7] = '{8'h00, 3'd1, 3'd2, 64'h8000000000000001, 64'h0200000000000004, 8'h04};

        reset     = 1'b1;
        enable    = 1'b1;
        mode      = 2'd0;
        lane_mask = 8'h00;
        delay     = 3'd0;
        bitslip   = 3'd0;
        sbits_in  = 64'hFFFF_FFFF_FFFF_FFFF;

        // Reset state
        tick();
        tick();
        check("reset_tx", tx_words, 64'd0);
        check("reset_sof", {56'd0, sof_word}, 64'd0);
        check("reset_cnt", {48'd0, frame_cnt}, 64'd0);
        reset = 1'b0;

        // Steady-state table
        for (int v = 0; v < 8; v++) begin
            lane_mask = vecs[v].mask;
            delay     = vecs[v].dly;
            bitslip   = vecs[v].slip;
            sbits_in  = vecs[v].sbits;
            repeat (12) tick();
            check($sformatf("vec%0d_tx", v), tx_words, vecs[v].exp_tx);
            check($sformatf("vec%0d_sof", v), {56'd0, sof_word}, {56'd0, vecs[v].exp_sof});
        end

        // Bit-slip of 3 across a word change on lane 0
        lane_mask = 8'h00;
        delay     = 3'd0;
        bitslip   = 3'd3;
        sbits_in  = 64'h00000000000000F0;
        repeat (6) tick();
        check("slip3_steady_f0", {56'd0, tx_words[7:0]}, 64'h87);
        check("slip3_sof", {56'd0, sof_word}, 64'h08);
        sbits_in = 64'h000000000000000F;
        repeat (3) tick();
        check("slip3_change", {56'd0, tx_words[7:0]}, 64'h7F);
        tick();
        check("slip3_steady_0f", {56'd0, tx_words[7:0]}, 64'h78);
        bitslip = 3'd0;

        // Latency with delay 5 then delay 0, mid-stream switch
        do_reset();
        for (int c = 0; c < 40; c++) begin
            sbits_in = {32'hA5A50000 | 32'(c), 32'(c * 7 + 3)};
            hist[c]  = sbits_in;
            delay    = (c < 20) ? 3'd5 : 3'd0;
            tick();
            if (c >= 12)
                check($sformatf("dly_stream_c%0d", c), tx_words, hist[c - 2 - int'(delay)]);
        end
        check("dly_stream_cnt", {48'd0, frame_cnt}, 64'd40);
        delay = 3'd0;

        // PRBS7
        mode = 2'd1;
        do_reset();
        for (int c = 0; c < 140; c++) begin
            tick();
            outb[c] = tx_words[7:0];
            if (c >= 2) check($sformatf("prbs_c%0d", c), tx_words, {8{prbs_byte(c - 2)}});
        end
        check("prbs_first_byte", {56'd0, outb[2]}, 64'h40);
        for (int c = 2; c < 13; c++)
            check($sformatf("prbs_period_%0d", c), {56'd0, outb[c]}, {56'd0, outb[c + 127]});
        lane_mask = 8'h04;
        tick();  // edge 140
        b   = prbs_byte(138);
        exp = {8{b}};
        exp[23:16] = 8'h00;
        check("prbs_mask_tx", tx_words, exp);
        check("prbs_mask_sof", {56'd0, sof_word}, 64'h01);
        lane_mask = 8'h00;

        // Enable off: counter and PRBS hold, pipeline drains
        enable = 1'b0;
        tick();  // edge 141
        check("en_off_cnt", {48'd0, frame_cnt}, 64'd141);
        check("en_off_drain1", tx_words, {8{prbs_byte(139)}});
        tick();  // edge 142
        check("en_off_drain2", tx_words, {8{prbs_byte(140)}});
        check("en_off_sof_drain", {56'd0, sof_word}, 64'h01);
        tick();  // edge 143
        check("en_off_tx", tx_words, 64'd0);
        check("en_off_sof", {56'd0, sof_word}, 64'd0);
        tick();
        tick();
        check("en_off_cnt_hold", {48'd0, frame_cnt}, 64'd141);
        enable = 1'b1;
        repeat (3) tick();
        check("en_on_prbs_resume", tx_words, {8{prbs_byte(141)}});
        check("en_on_sof", {56'd0, sof_word}, 64'h01);

        // Walking one
        mode = 2'd2;
        one  = 64'd1;
        do_reset();
        for (int c = 0; c < 70; c++) begin
            tick();
            if (c >= 2) check($sformatf("walk_c%0d", c), tx_words, one << ((c - 2) % 64));
        end
        check("walk_cnt", {48'd0, frame_cnt}, 64'd70);

        // Frame counter pattern
        mode = 2'd3;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            tick();
            b = 8'(c - 2);
            if (c >= 2) check($sformatf("fcnt_c%0d", c), tx_words, {8{b}});
        end

        // 16-bit wrap
        mode     = 2'd0;
        sbits_in = 64'd0;
        do_reset();
        repeat (65535) tick();
        check("wrap_ffff", {48'd0, frame_cnt}, 64'hFFFF);
        tick();
        check("wrap_0000", {48'd0, frame_cnt}, 64'h0000);

        // Reset mid-run
        sbits_in = 64'hDEADBEEFCAFEF00D;
        repeat (5) tick();
        check("midrst_pre", tx_words, 64'hDEADBEEFCAFEF00D);
        reset = 1'b1;
        tick();
        check("midrst_tx", tx_words, 64'd0);
        check("midrst_sof", {56'd0, sof_word}, 64'd0);
        check("midrst_cnt", {48'd0, frame_cnt}, 64'd0);
        reset = 1'b0;
        tick();
        check("midrst_e0", tx_words, 64'd0);
        tick();
        check("midrst_e1", tx_words, 64'd0);
        tick();
        check("midrst_e2", tx_words, 64'hDEADBEEFCAFEF00D);
        check("midrst_e2_sof", {56'd0, sof_word}, 64'h01);
        check("midrst_e2_cnt", {48'd0, frame_cnt}, 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
